// File: rtl/unidade_controle_if.sv
// Datapath-facing bundle of the control unit: instruction/register/memory
// inputs and the decoded control outputs.
interface unidade_controle_if;
    logic [7:0] instr;
    logic [7:0] Dado1;
    logic [7:0] Dado2;
    logic       mem_ready;
    logic [7:0] pc;
    logic [1:0] RegLido1;
    logic [1:0] RegLido2;
    logic [1:0] RegEscrito;
    logic       EscReg;
    logic [2:0] alu_op;
    logic [7:0] imm8;
    logic [1:0] wb_sel;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] estado;

    modport master (
        input  instr, Dado1, Dado2, mem_ready,
        output pc, RegLido1, RegLido2, RegEscrito, EscReg,
        output alu_op, imm8, wb_sel, mem_req, mem_we, estado
    );

    modport slave (
        output instr, Dado1, Dado2, mem_ready,
        input  pc, RegLido1, RegLido2, RegEscrito, EscReg,
        input  alu_op, imm8, wb_sel, mem_req, mem_we, estado
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit and program counter for the 8-bit,
// 4-register processor (FETCH/DECODE/EXEC/MEM/WB sequencer).
module unidade_controle #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input logic               clock,
    input logic               reset,
    unidade_controle_if.master bus
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [2:0] OP_LI  = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;
    localparam logic [2:0] OP_SW  = 3'b110;
    localparam logic [2:0] OP_BEQ = 3'b111;

    logic [2:0] estado_q;
    logic [2:0] estado_d;
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [7:0] ir_q;
    logic [2:0] opcode;
    logic [7:0] imm8;

    assign opcode = ir_q[7:5];
    assign imm8   = {{5{ir_q[2]}}, ir_q[2:0]};

    // Next-state and program-counter sequencing
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        case (estado_q)
            FETCH: begin
                estado_d = DECODE;
                pc_d     = pc_q + 8'd1;
            end
            DECODE: begin
                unique case (1'b1)
                    (opcode == OP_LI): estado_d = WB;
                    (opcode == OP_LW),
                    (opcode == OP_SW): estado_d = MEM;
                    default:           estado_d = EXEC;
                endcase
            end
            EXEC: begin
                if (opcode == OP_BEQ) begin
                    estado_d = FETCH;
                    // pc already holds the next address here
                    if (bus.Dado1 == bus.Dado2)
                        pc_d = pc_q + imm8;
                end else begin
                    estado_d = WB;
                end
            end
            MEM: begin
                if (bus.mem_ready)
                    estado_d = (opcode == OP_LW) ? WB : FETCH;
            end
            WB:      estado_d = FETCH;
            default: estado_d = FETCH;
        endcase
    end

    // State, pc and instruction register; reset wins over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= FETCH;
            pc_q     <= PC_RESET;
            ir_q     <= 8'h00;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            if (estado_q == FETCH)
                ir_q <= bus.instr;
        end
    end

    // Control outputs decoded from registered state and IR only
    always_comb begin
        bus.wb_sel = 2'b00;
        unique case (1'b1)
            (opcode == OP_LI): bus.wb_sel = 2'b01;
            (opcode == OP_LW): bus.wb_sel = 2'b10;
            default:           bus.wb_sel = 2'b00;
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.estado     = estado_q;
    assign bus.RegLido1   = ir_q[4:3];
    assign bus.RegLido2   = (opcode == OP_BEQ) ? 2'b10 : ir_q[2:1];
    assign bus.RegEscrito = ir_q[4:3];
    assign bus.EscReg     = (estado_q == WB);
    assign bus.alu_op     = ir_q[7] ? 3'b000 : opcode;
    assign bus.imm8       = imm8;
    assign bus.mem_req    = (estado_q == MEM);
    assign bus.mem_we     = (estado_q == MEM) && (opcode == OP_SW);

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized self-checking bench for unidade_controle against an
// instruction-level reference model.
module tb_unidade_controle;

    localparam logic [7:0] PC_RST = 8'h00;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [7:0] exp_pc;

    unidade_controle_if bus ();

    unidade_controle #(.PC_RESET(PC_RST)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, got, want, $time);
        end
    endtask

    // Checks the architectural reset state; entered and left at a negedge
    task automatic check_reset_state();
        chk("rst_estado", 8'(bus.estado), 8'd0);
        chk("rst_pc", bus.pc, PC_RST);
        chk("rst_EscReg", 8'(bus.EscReg), 8'd0);
        chk("rst_mem_req", 8'(bus.mem_req), 8'd0);
        chk("rst_mem_we", 8'(bus.mem_we), 8'd0);
        chk("rst_alu_op", 8'(bus.alu_op), 8'd0);
        chk("rst_imm8", bus.imm8, 8'd0);
        chk("rst_wb_sel", 8'(bus.wb_sel), 8'd0);
        chk("rst_RegLido1", 8'(bus.RegLido1), 8'd0);
        chk("rst_RegLido2", 8'(bus.RegLido2), 8'd0);
        chk("rst_RegEscrito", 8'(bus.RegEscrito), 8'd0);
        exp_pc = PC_RST;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'($urandom);
        bus.instr = 8'($urandom);
        @(negedge clock);
        reset = 1'b0;
        check_reset_state();
    endtask

    // Runs one instruction from its FETCH cycle; abort_k >= 0 asserts
    // reset in that cycle of the instruction's path instead of finishing
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] d1,
                             input logic [7:0] d2, input int w,
                             input int abort_k);
        int path[$];
        int op;
        int imm;
        int mcount;
        logic [7:0] start;
        logic [7:0] nxt;
        logic [7:0] e_imm8;
        logic [1:0] e_rl2;
        logic [2:0] e_alu;
        logic [1:0] e_wb;

        op     = int'(ins[7:5]);
        imm    = ins[2] ? int'(ins[2:0]) - 8 : int'(ins[2:0]);
        e_imm8 = 8'(imm);
        e_rl2  = (op == 7) ? 2'b10 : ins[2:1];
        e_alu  = (op < 4) ? 3'(op) : 3'd0;
        e_wb   = (op == 4) ? 2'b01 : (op == 5) ? 2'b10 : 2'b00;
        start  = exp_pc;
        nxt    = 8'(int'(start) + 1);
        if (op == 7 && d1 == d2)
            nxt = 8'(int'(nxt) + imm);

        path.push_back(0);
        path.push_back(1);
        if (op < 4) begin
            path.push_back(2);
            path.push_back(4);
        end else if (op == 4) begin
            path.push_back(4);
        end else if (op == 7) begin
            path.push_back(2);
        end else begin
            for (int i = 0; i <= w; i++) path.push_back(3);
            if (op == 5) path.push_back(4);
        end

        mcount = 0;
        for (int k = 0; k < path.size(); k++) begin
            int s;
            s = path[k];
            chk("estado", 8'(bus.estado), 8'(s));
            chk("pc", bus.pc, (k == 0) ? start : 8'(int'(start) + 1));
            chk("EscReg", 8'(bus.EscReg), 8'(s == 4));
            chk("mem_req", 8'(bus.mem_req), 8'(s == 3));
            if (s == 3)
                chk("mem_we", 8'(bus.mem_we), 8'(op == 6));
            if (k > 0) begin
                chk("RegLido1", 8'(bus.RegLido1), 8'(ins[4:3]));
                chk("RegLido2", 8'(bus.RegLido2), 8'(e_rl2));
                chk("RegEscrito", 8'(bus.RegEscrito), 8'(ins[4:3]));
                chk("alu_op", 8'(bus.alu_op), 8'(e_alu));
                chk("imm8", bus.imm8, e_imm8);
            end
            if (s == 4)
                chk("wb_sel", 8'(bus.wb_sel), 8'(e_wb));

            bus.instr = (k == 0) ? ins : 8'($urandom);
            bus.Dado1 = d1;
            bus.Dado2 = d2;
            if (s == 3) begin
                bus.mem_ready = (mcount == w);
                mcount++;
            end else begin
                bus.mem_ready = 1'($urandom);
            end

            if (k == abort_k) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("abort_mem_req", 8'(bus.mem_req), 8'd0);
                chk("abort_EscReg", 8'(bus.EscReg), 8'd0);
                chk("abort_estado", 8'(bus.estado), 8'd0);
                chk("abort_pc", bus.pc, PC_RST);
                exp_pc = PC_RST;
                return;
            end
            @(negedge clock);
        end
        exp_pc = nxt;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        exp_pc = PC_RST;
        bus.instr = 8'h00;
        bus.Dado1 = 8'h00;
        bus.Dado2 = 8'h00;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        do_reset();

        // ADD, LI, LW with wait, then pad pc to 5 for the branch cases
        run_instr(8'h2C, 8'h11, 8'h22, 0, -1);
        run_instr(8'h9D, 8'h00, 8'h00, 0, -1);
        run_instr(8'hA4, 8'h00, 8'h00, 3, -1);
        run_instr(8'h80, 8'h00, 8'h00, 0, -1);
        run_instr(8'h80, 8'h00, 8'h00, 0, -1);
        run_instr(8'hEE, 8'h07, 8'h07, 0, -1);
        run_instr(8'h80, 8'h00, 8'h00, 0, -1);
        run_instr(8'hEE, 8'h07, 8'h08, 0, -1);
        run_instr(8'hC2, 8'h33, 8'h44, 0, -1);
        run_instr(8'h00, 8'h00, 8'h00, 0, -1);

        // pc wrap in both directions via branches
        do_reset();
        run_instr(8'hEE, 8'h05, 8'h05, 0, -1);
        run_instr(8'hE3, 8'h09, 8'h09, 0, -1);
        run_instr(8'h00, 8'h00, 8'h00, 0, -1);

        // reset during the second MEM cycle of a load
        do_reset();
        run_instr(8'hA4, 8'h00, 8'h00, 3, 3);
        run_instr(8'h2C, 8'h01, 8'h02, 0, -1);

        // randomized instruction stream with occasional resets
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ins;
            logic [7:0] d1;
            logic [7:0] d2;
            int w;
            int ab;
            ins = 8'($urandom);
            d1  = 8'($urandom_range(0, 3));
            d2  = ($urandom_range(0, 1) == 1) ? d1 : 8'($urandom_range(0, 3));
            w   = $urandom_range(0, 4);
            ab  = ($urandom_range(0, 40) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(ins, d1, d2, w, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
